// File: rtl/divider_restoring_seq_if.sv
// rtl/divider_restoring_seq_if.sv - request/result bundle for the sequential restoring divider
//
// Purpose: groups the divider handshake and operand/result buses.
// Ports (signals):
//   start        request pulse, honoured only while busy=0
//   dividend     2*WIDTH-bit unsigned numerator
//   divisor      WIDTH-bit unsigned denominator
//   busy         high while iterating
//   done         one-cycle pulse when results are valid
//   quotient     2*WIDTH-bit unsigned result
//   remainder    WIDTH-bit unsigned result
//   div_by_zero  set together with done when the divisor was 0
// Modports: master drives the request side, slave (the divider) drives results.

interface divider_restoring_seq_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_restoring_seq.sv
// rtl/divider_restoring_seq.sv - sequential restoring divider, one quotient bit per clock
//
// Purpose: divides a 2*WIDTH-bit unsigned dividend by a WIDTH-bit unsigned
// divisor, producing quotient and remainder after 2*WIDTH iterations.
// A zero divisor completes immediately with quotient all ones,
// remainder = dividend[WIDTH-1:0] and div_by_zero set.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   dif    divider_restoring_seq_if.slave (start/operands in, results out)
// All outputs are registered.

module divider_restoring_seq #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    divider_restoring_seq_if.slave dif
);
    localparam int QW = 2 * WIDTH;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [QW-1:0]     q_q, q_d;        // quotient shift register, dividend shifts out the top
    logic [WIDTH:0]    p_q, p_d;        // partial remainder
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [QW-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              dbz_q, dbz_d;

    logic              accept;
    logic [WIDTH:0]    t_step;
    logic [WIDTH:0]    diff_step;
    logic              ge_step;
    logic [WIDTH:0]    p_step;
    logic [QW-1:0]     q_step;

    // A request is taken in IDLE and also in the DONE cycle (back-to-back).
    assign accept = dif.start && (state_q != S_RUN);

    // One restoring step. P < divisor holds between steps, so T <= 2*divisor-1
    // fits in WIDTH+1 bits and the top bit of P is never needed to form T.
    assign t_step    = {p_q[WIDTH-1:0], q_q[QW-1]};
    assign diff_step = t_step - {1'b0, dvs_q};
    assign ge_step   = (t_step >= {1'b0, dvs_q});
    assign p_step    = ge_step ? diff_step : t_step;
    assign q_step    = {q_q[QW-2:0], ge_step};

    logic unused_p_msb;
    assign unused_p_msb = p_q[WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            p_q     <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            p_q     <= p_d;
            dvs_q   <= dvs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                if (accept) begin
                    state_d = (dif.divisor == '0) ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        cnt_d  = cnt_q;
        q_d    = q_q;
        p_d    = p_q;
        dvs_d  = dvs_q;
        busy_d = busy_q;
        done_d = 1'b0;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        case (state_q)
            S_RUN: begin
                q_d   = q_step;
                p_d   = p_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    quo_d  = q_step;
                    rem_d  = p_step[WIDTH-1:0];
                    dbz_d  = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
                if (accept) begin
                    q_d   = dif.dividend;
                    dvs_d = dif.divisor;
                    p_d   = '0;
                    cnt_d = CW'(QW);
                    if (dif.divisor == '0) begin
                        done_d = 1'b1;
                        quo_d  = '1;
                        rem_d  = dif.dividend[WIDTH-1:0];
                        dbz_d  = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
            end
        endcase
    end

    assign dif.busy        = busy_q;
    assign dif.done        = done_q;
    assign dif.quotient    = quo_q;
    assign dif.remainder   = rem_q;
    assign dif.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_restoring_seq.sv
// tb/tb_divider_restoring_seq.sv - directed self-checking bench for divider_restoring_seq

module tb_divider_restoring_seq;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    divider_restoring_seq_if #(.WIDTH(WIDTH)) dif ();

    divider_restoring_seq #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the request is taken at the next rising edge and
    // the task returns at the falling edge just after it.
    task automatic start_op(input logic [7:0] dd, input logic [3:0] dv);
        dif.start    = 1'b1;
        dif.dividend = dd;
        dif.divisor  = dv;
        @(negedge clk);
        dif.start    = 1'b0;
    endtask

    // k counts rising edges after the accept edge; returns at the falling edge where done=1.
    task automatic wait_done(input string tag, output int nbusy, output int lat);
        bit seen;
        nbusy = 0;
        lat   = -1;
        seen  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (dif.done === 1'b1) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
            if (dif.busy === 1'b1) nbusy++;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run(input string tag, input logic [7:0] dd, input logic [3:0] dv,
                       input logic [7:0] eq, input logic [3:0] er, input logic ez);
        int nb;
        int lat;
        start_op(dd, dv);
        wait_done(tag, nb, lat);
        chk({tag, "_latency"}, 32'(lat), (dv == 0) ? 32'd0 : 32'd8);
        chk({tag, "_busy_cycles"}, 32'(nb), (dv == 0) ? 32'd0 : 32'd8);
        chk({tag, "_quotient"}, 32'(dif.quotient), 32'(eq));
        chk({tag, "_remainder"}, 32'(dif.remainder), 32'(er));
        chk({tag, "_div_by_zero"}, 32'(dif.div_by_zero), 32'(ez));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(dif.done), 32'd0);
    endtask

    initial begin
        int nb;
        int lat;
        bit got_done;
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_busy", 32'(dif.busy), 32'd0);
        chk("reset_done", 32'(dif.done), 32'd0);
        chk("reset_quotient", 32'(dif.quotient), 32'd0);
        chk("reset_remainder", 32'(dif.remainder), 32'd0);
        chk("reset_dbz", 32'(dif.div_by_zero), 32'd0);

        run("d15_3", 8'd15, 4'd3, 8'd5, 4'd0, 1'b0);
        run("d165_15", 8'd165, 4'd15, 8'd11, 4'd0, 1'b0);
        run("d225_15", 8'd225, 4'd15, 8'd15, 4'd0, 1'b0);
        run("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
        run("d100_7", 8'd100, 4'd7, 8'd14, 4'd2, 1'b0);
        run("d11_15", 8'd11, 4'd15, 8'd0, 4'd11, 1'b0);
        run("d0_9", 8'd0, 4'd9, 8'd0, 4'd0, 1'b0);
        run("d200_0", 8'd200, 4'd0, 8'd255, 4'd8, 1'b1);

        // Results hold through the next operation and div_by_zero clears at its done.
        start_op(8'd100, 4'd7);
        chk("hold_dbz", 32'(dif.div_by_zero), 32'd1);
        chk("hold_quotient", 32'(dif.quotient), 32'd255);
        chk("hold_busy", 32'(dif.busy), 32'd1);
        wait_done("clr", nb, lat);
        chk("clr_dbz", 32'(dif.div_by_zero), 32'd0);
        chk("clr_quotient", 32'(dif.quotient), 32'd14);
        chk("clr_remainder", 32'(dif.remainder), 32'd2);
        @(negedge clk);

        // start during RUN is ignored, then a back-to-back request in the DONE cycle.
        start_op(8'd100, 4'd7);
        repeat (3) @(negedge clk);
        start_op(8'd15, 4'd3);
        wait_done("ign", nb, lat);
        chk("ign_latency", 32'(lat), 32'd4);
        chk("ign_quotient", 32'(dif.quotient), 32'd14);
        chk("ign_remainder", 32'(dif.remainder), 32'd2);
        start_op(8'd165, 4'd15);
        chk("b2b_busy", 32'(dif.busy), 32'd1);
        chk("b2b_done", 32'(dif.done), 32'd0);
        wait_done("b2b", nb, lat);
        chk("b2b_latency", 32'(lat), 32'd8);
        chk("b2b_busy_cycles", 32'(nb), 32'd8);
        chk("b2b_quotient", 32'(dif.quotient), 32'd11);
        chk("b2b_remainder", 32'(dif.remainder), 32'd0);
        @(negedge clk);

        // Reset at RUN iteration 4 discards the operation.
        start_op(8'd100, 4'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(dif.busy), 32'd0);
        chk("abort_done", 32'(dif.done), 32'd0);
        chk("abort_quotient", 32'(dif.quotient), 32'd0);
        chk("abort_remainder", 32'(dif.remainder), 32'd0);
        chk("abort_dbz", 32'(dif.div_by_zero), 32'd0);
        got_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (dif.done === 1'b1 || dif.busy === 1'b1) got_done = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(got_done), 32'd0);
        run("d165_11", 8'd165, 4'd11, 8'd15, 4'd0, 1'b0);

        // Exhaustive sweep of all nonzero-divisor pairs.
        for (int dv = 1; dv < 16; dv++) begin
            for (int dd = 0; dd < 256; dd++) begin
                start_op(8'(dd), 4'(dv));
                wait_done("sweep", nb, lat);
                chk($sformatf("sweep_q_%0d_%0d", dd, dv), 32'(dif.quotient), 32'(dd / dv));
                chk($sformatf("sweep_r_%0d_%0d", dd, dv), 32'(dif.remainder), 32'(dd % dv));
                chk($sformatf("sweep_inv_%0d_%0d", dd, dv),
                    32'((32'(dif.quotient) * 32'(dv) + 32'(dif.remainder) == 32'(dd))
                        && (32'(dif.remainder) < 32'(dv))), 32'd1);
                @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
